// File: rtl/ram_stream_reader_if.sv
// Command and output-stream bundle for ram_stream_reader.
// slave is the reader's view; master is the commander/consumer view.
interface ram_stream_reader_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, m_ready,
    output cmd_ready, m_valid, m_data, m_last
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, m_ready,
    input  cmd_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams cmd_len words from a registered-read RAM starting at cmd_addr.
// Optional: define RAM_STREAM_READER_STALL_CNT_EN to add the stall_cnt output.
module ram_stream_reader #(
  parameter  int DW    = 8,
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_stream_reader_if.slave   bus,
  output logic [AW-1:0]        ram_addr,
  input  logic [DW-1:0]        ram_rd_data,
  output logic                 busy,
  output logic                 done
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [AW-1:0] ADDR_LAST = AW'(WORDS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   REM_ONE   = (AW+1)'(1);
  localparam int            FIFO_D    = 4;

  state_t        state_q, state_d;
  logic [AW:0]   rem_q;
  logic          rd_vld_q;
  logic          rd_last_q;
  logic          cmd_fire;
  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [AW-1:0] next_addr;

  logic [DW-1:0] fifo_data [FIFO_D];
  logic          fifo_last [FIFO_D];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic [2:0]    used;

  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  // Buffered words plus the one read in flight must fit the FIFO.
  assign used      = count + 3'(rd_vld_q);
  assign credit_ok = used < 3'(FIFO_D);
  assign issue     = (state_q == ISSUE) && credit_ok;
  assign push      = rd_vld_q;
  assign pop       = bus.m_valid && bus.m_ready;
  assign last_pop  = pop && bus.m_last;
  assign next_addr = (ram_addr == ADDR_LAST) ? '0 : ram_addr + ADDR_ONE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire && bus.cmd_len != '0) state_d = ISSUE;
      ISSUE:   if (issue && rem_q == REM_ONE)     state_d = DRAIN;
      DRAIN:   if (last_pop)                      state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue && (rem_q == REM_ONE);
      done      <= last_pop || (cmd_fire && bus.cmd_len == '0);
      if (cmd_fire) begin
        ram_addr <= bus.cmd_addr;
        rem_q    <= bus.cmd_len;
      end else if (issue) begin
        ram_addr <= next_addr;
        rem_q    <= rem_q - REM_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; empty-state outputs are masked instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_rd_data;
      fifo_last[wr_ptr] <= rd_last_q;
    end
  end

  always_comb begin
    bus.m_valid = (count != '0);
    bus.m_data  = '0;
    bus.m_last  = 1'b0;
    if (bus.m_valid) begin
      bus.m_data = fifo_data[rd_ptr];
      bus.m_last = fifo_last[rd_ptr];
    end
  end

`ifdef RAM_STREAM_READER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cmd_fire)
      stall_cnt <= '0;
    else if (bus.m_valid && !bus.m_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
